// File: rtl/mio_pkg.sv
// Shared definitions for the SCPU memory/IO responder: FSM state encoding and
// the MemRW direction constants.
package mio_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mio_word_ram.sv
// Single-port word storage: synchronous write, asynchronous read on the same
// address.
module mio_word_ram
  import mio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset; clearing it would turn storage into flops, and contents must survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mio_bus_responder.sv
// Responder for the SCPU CPU_MIO/MIO_ready handshake: latches one word request,
// waits WAIT_CYCLES cycles, then completes with a one-cycle MIO_ready pulse.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [WORD_W-1:0]     data_in_q, data_in_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  ram_we;
  logic                  unused_addr_bits;

  assign req_idx          = Addr_out[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{Addr_out[31:DEPTH_LOG2+2], Addr_out[1:0]};

  // In IDLE the RAM looks up the incoming address so a zero-wait read can be
  // captured on the accepting edge; otherwise it serves the latched index.
  assign ram_addr = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign ram_we   = (state_q == ST_RESP) && (rw_q == MEM_WRITE) && !rst;

  mio_word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;

    unique case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          rw_d    = MemRW;
          idx_d   = req_idx;
          wdata_d = Data_out;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RESP && rw_d == MEM_READ) data_in_d = ram_rdata;

    ready_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  // NOTE: non-blocking assignments let every flop sample the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rw_q      <= MEM_READ;
      idx_q     <= '0;
      wdata_q   <= '0;
      data_in_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign Data_in   = data_in_q;
  assign MIO_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized bench for mio_bus_responder: three instances (2, 0 and 15 wait
// states) checked against a word-array model of the handshake and storage.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mio [3];
  logic        MemRW;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] dout [3];
  logic        ready [3];
  logic        busy [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [3][1024];
  logic [31:0] last_rd [3];
  int          wr_q [3][$];

  always #5 clk = ~clk;

  mio_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[0]), .MemRW(MemRW), .Addr_out(Addr_out),
    .Data_out(Data_out), .Data_in(dout[0]), .MIO_ready(ready[0]), .busy(busy[0])
  );
  mio_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[1]), .MemRW(MemRW), .Addr_out(Addr_out),
    .Data_out(Data_out), .Data_in(dout[1]), .MIO_ready(ready[1]), .busy(busy[1])
  );
  mio_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[2]), .MemRW(MemRW), .Addr_out(Addr_out),
    .Data_out(Data_out), .Data_in(dout[2]), .MIO_ready(ready[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic int wait_of(input int sel);
    case (sel)
      0:       return 2;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % 1024);
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the idle
  // cycle that follows the response.
  task automatic run_txn(input int sel, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
    int w     = wait_of(sel);
    int idx   = word_of(addr);
    int bcnt  = 0;
    MemRW     = rw;
    Addr_out  = addr;
    Data_out  = wdata;
    mio[sel]  = 1'b1;
    for (int k = 0; k <= w + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy[sel]) bcnt++;
      check($sformatf("busy[%0d] k=%0d", sel, k), {31'b0, busy[sel]}, {31'b0, k <= w});
      check($sformatf("ready[%0d] k=%0d", sel, k), {31'b0, ready[sel]}, {31'b0, k == w});
      if (k == w) begin
        if (!rw) last_rd[sel] = model_mem[sel][idx];
        check($sformatf("data_in[%0d]", sel), dout[sel], last_rd[sel]);
        if (rw) begin
          model_mem[sel][idx] = wdata;
          wr_q[sel].push_back(idx);
        end
        if (!hold) mio[sel] = 1'b0;
      end else if (k < w) begin
        MemRW    = 1'($urandom);
        Addr_out = $urandom;
        Data_out = $urandom;
      end else begin
        check($sformatf("data_hold[%0d]", sel), dout[sel], last_rd[sel]);
      end
    end
    check($sformatf("busy_len[%0d]", sel), bcnt, w + 1);
  endtask

  task automatic random_txns(input int sel, input int n);
    for (int t = 0; t < n; t++) begin
      bit          rw;
      int          idx;
      logic [31:0] addr;
      rw = (wr_q[sel].size() == 0) || ($urandom_range(0, 1) == 1);
      if (rw) idx = $urandom_range(0, 1023);
      else    idx = wr_q[sel][$urandom_range(0, wr_q[sel].size() - 1)];
      addr = ($urandom << 12) | (idx << 2) | $urandom_range(0, 3);
      run_txn(sel, rw, addr, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    MemRW    = 1'b0;
    Addr_out = '0;
    Data_out = '0;
    for (int s = 0; s < 3; s++) begin
      mio[s]     = 1'b0;
      last_rd[s] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_ready[%0d]", s), {31'b0, ready[s]}, 32'd0);
      check($sformatf("rst_busy[%0d]", s), {31'b0, busy[s]}, 32'd0);
      check($sformatf("rst_data[%0d]", s), dout[s], 32'd0);
    end

    // Read after write at default latency, then aliasing with ignored low bits.
    run_txn(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0);
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("rd_deadbeef", dout[0], 32'hDEADBEEF);
    run_txn(0, 1'b1, 32'h0000_1013, 32'h1234_5678, 1'b0);
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("rd_alias", dout[0], 32'h1234_5678);

    // Zero wait states with the strobe held across back-to-back requests.
    run_txn(1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b1);
    run_txn(1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    check("rd_w0_b2b", dout[1], 32'hCAFE_F00D);

    // Fifteen wait states.
    run_txn(2, 1'b1, 32'h0000_0204, 32'h0BAD_CAFE, 1'b0);
    run_txn(2, 1'b0, 32'hFFFF_F204, 32'h0, 1'b0);
    check("rd_w15", dout[2], 32'h0BAD_CAFE);

    // Reset landing on the RESP cycle of a write must drop the write.
    run_txn(0, 1'b1, 32'h0000_0040, 32'h0, 1'b0);
    MemRW    = 1'b1;
    Addr_out = 32'h0000_0040;
    Data_out = 32'hA5A5A5A5;
    mio[0]   = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("resp_before_rst", {31'b0, ready[0]}, 32'd1);
    rst    = 1'b1;
    mio[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    check("rst_resp_ready", {31'b0, ready[0]}, 32'd0);
    check("rst_resp_busy", {31'b0, busy[0]}, 32'd0);
    check("rst_resp_data", dout[0], 32'd0);
    @(negedge clk);
    check("rst_no_pulse", {31'b0, ready[0]}, 32'd0);
    run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    check("rd_after_rst", dout[0], 32'h0);

    random_txns(0, 40);
    random_txns(1, 40);
    random_txns(2, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
